// File: rtl/byte_mem_ctrl.sv
// Byte-addressable little-endian memory controller with fixed response latency.
// Memory is four byte-lane RAMs indexed by word address; aligned accesses never span words.
module byte_mem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [1:0]        size_i,
  input  logic              sext_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int         AW       = $clog2(DEPTH_BYTES);
  localparam int         WORDS    = DEPTH_BYTES / 4;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              ready_reg;
  logic              rvalid_reg;
  logic              err_out_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              we_reg;
  logic              sext_reg;
  logic              err_reg;
  logic [1:0]        size_reg;
  logic [AW-1:0]     addr_reg;
  logic [31:0]       wdata_reg;

  logic              accept;
  logic              enter_resp;
  logic              req_err;
  logic [32:0]       span;
  logic [32:0]       last_byte;

  logic              op_we;
  logic              op_err;
  logic [1:0]        op_size;
  logic [AW-1:0]     op_addr;
  logic [31:0]       op_wdata;
  logic [3:0]        lane_mask;
  logic [31:0]       wd_rep;
  logic [AW-3:0]     word_idx;
  logic [31:0]       rd_word;

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_val;

  // Fault decode on the live request; 33-bit sum so a top-of-space address cannot wrap.
  always_comb begin
    span = 33'd0;
    case (size_i)
      2'b01:   span = 33'd1;
      2'b10:   span = 33'd3;
      default: span = 33'd0;
    endcase
    last_byte = {1'b0, addr_i} + span;
    req_err   = (size_i == 2'b11)
             || (size_i == 2'b01 && addr_i[0])
             || (size_i == 2'b10 && addr_i[1:0] != 2'b00)
             || (last_byte >= 33'(DEPTH_BYTES));
  end

  assign accept     = req_i && ready_reg && !rst_i;
  assign enter_resp = !rst_i && ((state_reg == WAIT && cnt_reg == 4'd1) || (LATENCY == 1 && accept));

  // With single-cycle latency the memory operation happens on the accepting edge itself.
  if (LATENCY == 1) begin : g_op_live
    assign op_we    = we_i;
    assign op_err   = req_err;
    assign op_size  = size_i;
    assign op_addr  = addr_i[AW-1:0];
    assign op_wdata = wdata_i[31:0];
  end else begin : g_op_held
    assign op_we    = we_reg;
    assign op_err   = err_reg;
    assign op_size  = size_reg;
    assign op_addr  = addr_reg;
    assign op_wdata = wdata_reg;
  end

  always_comb begin
    lane_mask = 4'b0000;
    wd_rep    = op_wdata;
    case (op_size)
      2'b00: begin
        lane_mask = 4'b0001 << op_addr[1:0];
        wd_rep    = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = op_addr[1] ? 4'b1100 : 4'b0011;
        wd_rep    = {2{op_wdata[15:0]}};
      end
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  assign word_idx = op_addr[AW-1:2];

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [WORDS];
    logic [7:0] rd_q;
    always_ff @(posedge clk_i) begin
      if (enter_resp) begin
        if (op_we && !op_err && lane_mask[gi]) begin
          mem[word_idx] <= wd_rep[8*gi +: 8];
        end
        rd_q <= mem[word_idx];
      end
    end
    assign rd_word[8*gi +: 8] = rd_q;
  end

  always_comb begin
    ld_byte = rd_word[{addr_reg[1:0], 3'b000} +: 8];
    ld_half = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
    ld_val  = '0;
    case (size_reg)
      2'b00:   ld_val = sext_reg ? DATA_W'($signed(ld_byte)) : DATA_W'(ld_byte);
      2'b01:   ld_val = sext_reg ? DATA_W'($signed(ld_half)) : DATA_W'(ld_half);
      2'b10:   ld_val = sext_reg ? DATA_W'($signed(rd_word)) : DATA_W'(rd_word);
      default: ld_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_reg    <= we_i;
      sext_reg  <= sext_i;
      err_reg   <= req_err;
      size_reg  <= size_i;
      addr_reg  <= addr_i[AW-1:0];
      wdata_reg <= wdata_i[31:0];
    end
  end

  // The response pulse is registered out of RESP, so a new accept in RESP overlaps it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      ready_reg   <= 1'b1;
      rvalid_reg  <= 1'b0;
      err_out_reg <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      rvalid_reg  <= (state_reg == RESP);
      err_out_reg <= (state_reg == RESP) && err_reg;
      rdata_reg   <= (state_reg == RESP && !we_reg && !err_reg) ? ld_val : '0;
      case (state_reg)
        WAIT: begin
          if (cnt_reg == 4'd1) begin
            state_reg <= RESP;
            cnt_reg   <= '0;
            ready_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state_reg <= RESP;
              ready_reg <= 1'b1;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= CNT_INIT;
              ready_reg <= 1'b0;
            end
          end else begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  assign ready_o  = ready_reg;
  assign rvalid_o = rvalid_reg;
  assign rdata_o  = rdata_reg;
  assign err_o    = err_out_reg;

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Bench for byte_mem_ctrl: three instances at latencies 2, 1 and 8 share stimulus;
// expected responses are queued at accept time and popped when rvalid_o pulses.
module tb_byte_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] wdata;
  logic        req    [3];
  logic        ready  [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic        err    [3];

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    byte_mem_ctrl #(
      .DATA_W(32),
      .DEPTH_BYTES(256),
      .LATENCY(gi == 0 ? 2 : (gi == 1 ? 1 : 8))
    ) u_dut (
      .clk_i(clk),
      .rst_i(rst),
      .req_i(req[gi]),
      .we_i(we),
      .addr_i(addr),
      .size_i(size),
      .sext_i(sext),
      .wdata_i(wdata),
      .ready_o(ready[gi]),
      .rvalid_o(rvalid[gi]),
      .rdata_o(rdata[gi]),
      .err_o(err[gi])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 8);
  endfunction

  // One request on instance k, then wait for and score its response.
  task automatic do_access(input int k, input logic w, input logic [31:0] a, input logic [1:0] s,
                           input logic sx, input logic [31:0] wd, input logic [31:0] exp_d,
                           input logic exp_e, input string name);
    exp_t e;
    bit   got;
    int   t;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (ready[k]) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s dut%0d: ready_o stayed 0, required 1", name, k);
      return;
    end
    we = w; addr = a; size = s; sext = sx; wdata = wd; req[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[k] = 1'b0;
    t = cyc;
    sb.push_back('{exp_d, exp_e, t + lat_of(k)});
    got = 0;
    for (int i = 0; i < 16; i++) begin
      if (rvalid[k]) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    n_assert++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s dut%0d: no rvalid_o pulse, required one at cycle %0d", name, k, e.due);
      return;
    end
    if (cyc !== e.due) begin
      n_fail++;
      $display("FAIL %s dut%0d latency: rvalid_o at cycle %0d, required %0d", name, k, cyc, e.due);
    end
    n_assert++;
    if (rdata[k] !== e.data) begin
      n_fail++;
      $display("FAIL %s dut%0d rdata: got %h, required %h", name, k, rdata[k], e.data);
    end
    n_assert++;
    if (err[k] !== e.err) begin
      n_fail++;
      $display("FAIL %s dut%0d err: got %b, required %b", name, k, err[k], e.err);
    end
    $display("txn %s dut%0d we=%b addr=%h size=%b sext=%b -> rdata=%h err=%b cycle=%0d",
             name, k, w, a, s, sx, rdata[k], err[k], cyc);
    @(negedge clk);
    n_assert++;
    if ({rvalid[k], err[k], rdata[k]} !== 34'b0) begin
      n_fail++;
      $display("FAIL %s dut%0d idle outputs: rvalid/err/rdata=%b/%b/%h, required 0/0/0",
               name, k, rvalid[k], err[k], rdata[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_assert++;
      if ({ready[k], rvalid[k], err[k], rdata[k]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
        n_fail++;
        $display("FAIL reset dut%0d: ready/rvalid/err/rdata=%b/%b/%b/%h, required 1/0/0/0",
                 k, ready[k], rvalid[k], err[k], rdata[k]);
      end
    end
  endtask

  task automatic test_roundtrip();
    for (int k = 0; k < 3; k++) begin
      do_access(k, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, "rt_store");
      do_access(k, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, "rt_load");
    end
  endtask

  task automatic test_extension();
    do_access(0, 1'b0, 32'h10, 2'b00, 1'b1, 32'h0, 32'hFFFFFFEF, 1'b0, "ld_sbyte");
    do_access(0, 1'b0, 32'h10, 2'b00, 1'b0, 32'h0, 32'h000000EF, 1'b0, "ld_ubyte");
    do_access(0, 1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 32'hFFFFDEAD, 1'b0, "ld_shalf");
    do_access(0, 1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 32'h0000DEAD, 1'b0, "ld_uhalf");
    do_access(0, 1'b1, 32'h40, 2'b01, 1'b0, 32'hFFFFA5C3, 32'h0, 1'b0, "st_half40");
    do_access(0, 1'b0, 32'h41, 2'b00, 1'b1, 32'h0, 32'hFFFFFFA5, 1'b0, "ld_sbyte41");
    do_access(0, 1'b0, 32'h40, 2'b00, 1'b0, 32'h0, 32'h000000C3, 1'b0, "ld_ubyte40");
    do_access(0, 1'b1, 32'hFF, 2'b00, 1'b0, 32'h0000005A, 32'h0, 1'b0, "st_byte_top");
    do_access(0, 1'b0, 32'hFF, 2'b00, 1'b1, 32'h0, 32'h0000005A, 1'b0, "ld_byte_top");
  endtask

  task automatic test_faults();
    do_access(0, 1'b1, 32'h11, 2'b10, 1'b0, 32'h01020304, 32'h0, 1'b1, "st_misalign");
    do_access(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, "ld_after_fault");
    do_access(0, 1'b0, 32'hFE, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, "ld_overrun");
    do_access(0, 1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, "ld_size11");
    do_access(0, 1'b0, 32'hFF, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1, "ld_half_odd");
    do_access(0, 1'b1, 32'h100, 2'b00, 1'b0, 32'h77, 32'h0, 1'b1, "st_past_end");
    do_access(0, 1'b1, 32'hFC, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0, "st_last_word");
    do_access(0, 1'b0, 32'hFC, 2'b10, 1'b0, 32'h0, 32'h11223344, 1'b0, "ld_last_word");
  endtask

  // req_i held high for six edges at latency 2: accepts land on edges 0, 2 and 4.
  task automatic test_busy_ignore();
    exp_t e;
    int   seen;
    logic exp_rdy;
    we = 1'b0; addr = 32'h10; size = 2'b10; sext = 1'b0;
    for (int i = 0; i < 6; i += 2) sb.push_back('{32'hDEADBEEF, 1'b0, i + 2});
    seen = 0;
    req[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 5) req[0] = 1'b0;
      if (i < 6) begin
        exp_rdy = (i % 2 == 1);
        n_assert++;
        if (ready[0] !== exp_rdy) begin
          n_fail++;
          $display("FAIL busy ready edge %0d: got %b, required %b", i, ready[0], exp_rdy);
        end
      end
      if (rvalid[0]) begin
        seen++;
        n_assert++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL busy extra response at edge %0d: got rvalid_o=1, required 0", i);
        end else begin
          e = sb.pop_front();
          if (e.due !== i || rdata[0] !== e.data) begin
            n_fail++;
            $display("FAIL busy response: edge %0d rdata %h, required edge %0d rdata %h",
                     i, rdata[0], e.due, e.data);
          end
          $display("txn busy dut0 response edge=%0d rdata=%h", i, rdata[0]);
        end
      end
    end
    n_assert++;
    if (seen != 3) begin
      n_fail++;
      $display("FAIL busy count: got %0d responses, required 3", seen);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_access(0, 1'b1, 32'h20, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, "rm_prime");
    we = 1'b1; addr = 32'h20; size = 2'b10; sext = 1'b0; wdata = 32'h12345678;
    req[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    n_assert++;
    if (ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_accept: ready_o=%b in WAIT, required 0", ready[0]);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (rvalid[0]) pulses++;
      @(negedge clk);
    end
    n_assert++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL rm_no_resp: got %0d rvalid_o pulses, required 0", pulses);
    end
    $display("txn rm_abort dut0 store 12345678 @20 aborted, pulses=%0d", pulses);
    do_access(0, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, "rm_load");
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = '0; size = '0; sext = 1'b0; wdata = '0;
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    test_reset();
    test_roundtrip();
    test_extension();
    test_faults();
    test_busy_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/byte_mem_ctrl.md
BYTE_MEM_CTRL -- requirements
Module: byte_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data word width in bits (multiple of 8, at least 32).
REQ-002 SHALL have parameter DEPTH_BYTES, default 256, meaning memory size in bytes (power of 2).
REQ-003 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response (legal range 1..8).
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  synchronous active-high reset.
- req_i  input  1  request strobe.
- we_i  input  1  1 = store, 0 = load.
- addr_i  input  32  byte address.
- size_i  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- sext_i  input  1  load sign-extend enable (1 = signed).
- wdata_i  input  DATA_W  store data; low-order bytes used per size.
- ready_o  output  1  controller can accept a request this cycle.
- rvalid_o  output  1  response valid, one-cycle pulse.
- rdata_o  output  DATA_W  load result.
- err_o  output  1  request faulted; valid only while rvalid_o is high.

Function
REQ-005 SHALL store bytes little-endian: byte k of an access goes to address addr_i+k, wdata_i[8k+7:8k].
REQ-006 SHALL accept a request on a rising edge where req_i=1 and ready_o=1, capturing all request inputs at that edge.
REQ-007 SHALL implement FSM states IDLE, WAIT and RESP:
- IDLE: ready_o=1; on accept, go to WAIT with counter=LATENCY-1.
- WAIT: ready_o=0; decrement the counter each edge; go to RESP when it reaches 0.
- RESP: rvalid_o=1 and ready_o=1 for one cycle.
- From RESP: an accept goes to WAIT; otherwise go to IDLE.
- For LATENCY=1, WAIT is skipped and RESP follows acceptance directly.
REQ-008 SHALL assert rvalid_o in the cycle beginning exactly LATENCY edges after the accepting edge.
REQ-009 SHALL ignore req_i while ready_o=0; requests are neither queued nor acknowledged.
REQ-010 SHALL commit a store on the edge that enters RESP, and SHALL leave the memory unmodified outside that edge.
REQ-011 SHALL read a load's data on the edge that enters RESP, so the load reflects every store committed on earlier edges.
REQ-012 SHALL return byte and half loads in the low bits of rdata_o:
- Upper bits are zero-extended when sext_i=0.
- Upper bits are filled with the top loaded bit when sext_i=1.
REQ-013 SHALL drive rdata_o to 0 for store responses and for faulted responses.
REQ-014 SHALL flag err_o=1 for any of these requests:
- size_i=11.
- A misaligned address: half with addr[0]=1, or word with addr[1:0]!=0.
- A range overrun: addr_i+bytes-1 >= DEPTH_BYTES.
REQ-015 SHALL suppress the memory write for a faulted store, with the same latency as a good access.
REQ-016 SHALL hold rdata_o and err_o at 0 whenever rvalid_o=0.
REQ-017 SHALL perform no address wrap-around; an out-of-range access faults per REQ-014.
REQ-018 SHALL sustain back-to-back accesses: one request per LATENCY cycles when an accept occurs in RESP.

Reset
REQ-019 SHALL, while rst_i=1 at an edge, enter IDLE and clear the counter, giving rvalid_o=0, rdata_o=0, err_o=0 and ready_o=1 from the following cycle.
REQ-020 SHALL abandon an in-flight access when reset is asserted mid-operation, with no memory write and no response.
REQ-021 SHALL NOT clear memory contents on reset.

Verification
REQ-022 SHALL pass a word round-trip at LATENCY=2: store 0xDEADBEEF to address 0x10, then load a word from 0x10 -> rvalid_o exactly 2 cycles after each accept, rdata_o=0xDEADBEEF, err_o=0.
REQ-023 SHALL pass a byte/half extension check: after REQ-022, load a signed byte from 0x10 -> 0xFFFFFFEF; unsigned byte -> 0x000000EF; signed half from 0x12 -> 0xFFFFDEAD; unsigned half from 0x12 -> 0x0000DEAD.
REQ-024 SHALL pass a faults check: store a word to 0x11 -> err_o=1 and a subsequent load of 0x10 still returns 0xDEADBEEF; load a word from DEPTH_BYTES-2 -> err_o=1; size_i=11 -> err_o=1, rdata_o=0.
REQ-025 SHALL pass a busy-ignore check: assert req_i every cycle for 6 cycles with LATENCY=2 -> exactly 3 responses, with ready_o=0 during every WAIT cycle.
REQ-026 SHALL pass a reset mid-operation check: accept a store of 0x12345678 to 0x20, assert rst_i during WAIT -> no rvalid_o pulse, and a later load of 0x20 returns the prior contents.
REQ-027 SHALL pass a latency sweep: repeat REQ-022 with LATENCY=1 and LATENCY=8 -> rvalid_o 1 and 8 cycles after accept respectively.
